// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time program loader driving the imem write port
module imem_boot_loader
    import fetch_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_waddr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            load_done
);

    logic [XLEN-1:0] wcnt;
    logic            beat;

    assign ld_ready   = active;
    assign beat       = ld_valid & active;
    assign imem_we    = beat;
    assign imem_waddr = wcnt << 2;
    assign imem_wdata = ld_data;

    // The final slot ends the load even without ld_last, so the write never overruns DEPTH.
    assign load_done  = beat & (ld_last | (wcnt == XLEN'(DEPTH - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (beat) begin
            wcnt <= wcnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - boot loader sequencing, PC and IF register for the 3-stage pipeline
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 100,
    parameter logic [XLEN-1:0] NOP      = NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_waddr,
    output logic [XLEN-1:0] imem_wdata,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid,
    output logic            running,
    output logic            halted
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            load_done;
    logic            unused_br_lsbs;

    imem_boot_loader #(
        .DEPTH (DEPTH)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .active     (state == LOAD),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .load_done  (load_done)
    );

    assign imem_addr      = pc;
    assign running        = (state == RUN);
    assign halted         = (state == HALT);
    assign unused_br_lsbs = ^br_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            pc       <= RESET_PC;
            if_inst  <= NOP;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A redirect wins over a stall: the stalled word is on the wrong path anyway.
                    if (br_taken) begin
                        pc       <= {br_target[XLEN-1:2], 2'b00};
                        if_inst  <= NOP;
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (pc >= XLEN'(DEPTH * 4)) begin
                        state    <= HALT;
                        if_inst  <= NOP;
                        if_valid <= 1'b0;
                    end else begin
                        if_inst  <= imem_data;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        ld_valid, ld_last, stall, br_taken;
    logic [31:0] ld_data, br_target;

    logic        a_ready, a_we, a_ifv, a_run, a_halt;
    logic [31:0] a_waddr, a_wdata, a_addr, a_idata, a_ifpc, a_inst;
    logic        b_ready, b_we, b_ifv, b_run, b_halt;
    logic [31:0] b_waddr, b_wdata, b_addr, b_idata, b_ifpc, b_inst;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:7];
    logic [31:0] w [0:3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut_a (
        .clk(clk), .rst(rst_a),
        .ld_valid(ld_valid), .ld_ready(a_ready), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(a_we), .imem_waddr(a_waddr), .imem_wdata(a_wdata),
        .imem_addr(a_addr), .imem_data(a_idata),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .if_pc(a_ifpc), .if_inst(a_inst), .if_valid(a_ifv),
        .running(a_run), .halted(a_halt)
    );

    imem_fetch_ctrl #(.DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .ld_valid(ld_valid), .ld_ready(b_ready), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(b_we), .imem_waddr(b_waddr), .imem_wdata(b_wdata),
        .imem_addr(b_addr), .imem_data(b_idata),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .if_pc(b_ifpc), .if_inst(b_inst), .if_valid(b_ifv),
        .running(b_run), .halted(b_halt)
    );

    always @(posedge clk) begin
        if (a_we) mem_a[a_waddr[8:2]] <= a_wdata;
        if (b_we) mem_b[b_waddr[4:2]] <= b_wdata;
    end
    assign a_idata = mem_a[a_addr[8:2]];
    assign b_idata = mem_b[b_addr[4:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113; w[2] = 32'h0020_81B3; w[3] = 32'h0030_0193;
        for (int i = 0; i < 128; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem_b[i] = 32'h0;
        rst_a = 1; rst_b = 1; ld_valid = 0; ld_last = 0; ld_data = 0;
        stall = 0; br_taken = 0; br_target = 0;
        step(); step();

        // reset state
        chk("rst_running", a_run, 0);
        chk("rst_halted", a_halt, 0);
        chk("rst_if_inst", a_inst, 32'h13);
        chk("rst_if_valid", a_ifv, 0);
        chk("rst_if_pc", a_ifpc, 0);
        chk("rst_imem_we", a_we, 0);
        chk("rst_imem_addr", a_addr, 0);
        rst_a = 0;

        // 1: three-word boot, ld_last on the third
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = w[i]; ld_last = (i == 2);
            #1;
            chk($sformatf("ld%0d_we", i), a_we, 1);
            chk($sformatf("ld%0d_waddr", i), a_waddr, 32'(i * 4));
            chk($sformatf("ld%0d_wdata", i), a_wdata, w[i]);
            chk($sformatf("ld%0d_ready", i), a_ready, 1);
            chk($sformatf("ld%0d_running", i), a_run, 0);
            step();
        end
        ld_last = 0; ld_data = 32'hFFFF_FFFF;
        #1;
        chk("boot_running", a_run, 1);
        chk("boot_ready", a_ready, 0);
        chk("boot_we_ignored", a_we, 0);
        chk("boot_if_valid", a_ifv, 0);
        chk("boot_imem_addr", a_addr, 0);
        ld_valid = 0;

        // 2: sequential fetch
        step();
        chk("f0_pc", a_ifpc, 0); chk("f0_inst", a_inst, w[0]); chk("f0_valid", a_ifv, 1);
        chk("f0_addr", a_addr, 4);
        step();
        chk("f1_pc", a_ifpc, 4); chk("f1_inst", a_inst, w[1]); chk("f1_addr", a_addr, 8);

        // 3: two-cycle stall at pc=0x8
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("st%0d_pc", i), a_ifpc, 4);
            chk($sformatf("st%0d_inst", i), a_inst, w[1]);
            chk($sformatf("st%0d_addr", i), a_addr, 8);
            chk($sformatf("st%0d_valid", i), a_ifv, 1);
        end
        stall = 0;
        step();
        chk("res_pc", a_ifpc, 8); chk("res_inst", a_inst, w[2]); chk("res_addr", a_addr, 32'hC);

        // 4: misaligned branch with simultaneous stall
        br_taken = 1; br_target = 32'h0000_0006; stall = 1;
        step();
        chk("br_inst", a_inst, 32'h13); chk("br_valid", a_ifv, 0); chk("br_addr", a_addr, 4);
        br_taken = 0; stall = 0;
        step();
        chk("br_fetch_pc", a_ifpc, 4); chk("br_fetch_inst", a_inst, w[1]);
        chk("br_fetch_valid", a_ifv, 1);

        // 6: reset after 2 of 5 beats, then single-word reload
        rst_a = 1; step(); rst_a = 0;
        chk("rl_ready", a_ready, 1); chk("rl_running", a_run, 0); chk("rl_valid", a_ifv, 0);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1; ld_data = w[3]; #1;
            chk($sformatf("part%0d_waddr", i), a_waddr, 32'(i * 4));
            step();
        end
        rst_a = 1; step(); rst_a = 0;
        ld_valid = 1; ld_last = 1; ld_data = 32'h0010_0093; #1;
        chk("rl_we", a_we, 1); chk("rl_waddr", a_waddr, 0); chk("rl_wdata", a_wdata, 32'h0010_0093);
        step();
        ld_valid = 0; ld_last = 0;
        chk("rl_run", a_run, 1);
        step();
        chk("rl_fetch_inst", a_inst, 32'h0010_0093); chk("rl_fetch_pc", a_ifpc, 0);
        rst_a = 1;

        // 5: DEPTH=4 instance, load ends on the last slot, then halts
        chk("b_rst_running", b_run, 0); chk("b_rst_halted", b_halt, 0);
        rst_b = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = w[i]; #1;
            chk($sformatf("bld%0d_waddr", i), b_waddr, 32'(i * 4));
            step();
        end
        ld_valid = 0;
        chk("b_running", b_run, 1); chk("b_ready", b_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bf%0d_pc", i), b_ifpc, 32'(i * 4));
            chk($sformatf("bf%0d_inst", i), b_inst, w[i]);
            chk($sformatf("bf%0d_valid", i), b_ifv, 1);
        end
        step();
        chk("b_halted", b_halt, 1); chk("b_halt_valid", b_ifv, 0);
        chk("b_halt_run", b_run, 0); chk("b_halt_inst", b_inst, 32'h13);
        br_taken = 1; br_target = 32'h0;
        step();
        br_taken = 0;
        step();
        chk("b_br_halted", b_halt, 1); chk("b_br_addr", b_addr, 32'h10); chk("b_br_valid", b_ifv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequences the instruction memory for the 3-stage pipeline.
- After reset it runs a boot phase: it accepts program words over a valid/ready stream and writes them into the instruction memory through a synchronous write port.
- It then switches to run mode. In run mode it owns the PC, drives the asynchronous read address, and registers the fetched word into the IF/EX pipeline register.
- Run mode handles stall, branch redirect and out-of-range halt.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after boot.
- DEPTH, 100, instruction memory size in 32-bit words; bounds both load and fetch.
- NOP, 32'h0000_0013, word injected into the IF register on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  block accepts a loader word (1 only in LOAD state).
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks the final word of the program.
- imem_we  out  1  instruction memory write enable; memory writes on clk edge.
- imem_waddr  out  32  byte address of the write (word index << 2).
- imem_wdata  out  32  write data.
- imem_addr  out  32  byte read address to the instruction memory (asynchronous read).
- imem_data  in  32  read data, valid in the same cycle as imem_addr.
- stall  in  1  hazard stall from the downstream stage.
- br_taken  in  1  branch/jump resolved taken in EX.
- br_target  in  32  redirect byte address.
- if_pc  out  32  PC of the instruction held in the IF register.
- if_inst  out  32  registered instruction.
- if_valid  out  1  IF register holds a real instruction.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.

Behaviour:
Reset:
- On rst=1 at a clk edge: state=LOAD, pc=RESET_PC, wcnt=0, if_inst=NOP, if_pc=0, if_valid=0.
- running=0, halted=0, imem_we=0.
- Memory contents are not cleared.
- Reset asserted mid-load or mid-run restarts the boot from wcnt=0.

LOAD state:
- ld_ready=1.
- Beat = ld_valid & ld_ready. On a beat, combinationally: imem_we=1, imem_waddr=wcnt<<2, imem_wdata=ld_data. At the edge, wcnt<=wcnt+1.
- On a beat with ld_last=1, or with wcnt==DEPTH-1, the next state is RUN. The beat's word is still written.
- A write beyond DEPTH is impossible.
- imem_addr=pc. The IF register holds NOP, if_valid=0.

RUN state:
- ld_ready=0; ld_valid is ignored. imem_we=0.
- imem_addr=pc. Per-edge priority:
  1. br_taken: pc<={br_target[31:2],2'b00}, if_inst<=NOP, if_valid<=0. Branch overrides a simultaneous stall.
  2. stall: pc, if_inst, if_pc and if_valid all hold.
  3. pc >= DEPTH*4: next state HALT, if_inst<=NOP, if_valid<=0.
  4. Otherwise: if_inst<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+4.
- Latency: the first edge in RUN fetches RESET_PC, so if_valid=1 one cycle after entering RUN.
- The fetch after a redirect is valid two cycles after br_taken (one bubble).

HALT state:
- Terminal. Outputs hold with if_valid=0, halted=1.
- br_taken and stall are ignored. Only rst exits.

Arithmetic:
- PC is 32-bit unsigned.
- The pc+4 wrap at 2^32 is unreachable because the DEPTH*4 check halts first.
- Misaligned br_target low bits are discarded silently.

Decomposition:
- fetch_pkg holds:
  - state enum {LOAD, RUN, HALT};
  - NOP_INSN constant;
  - XLEN=32 localparam.
- One natural sub-module, imem_boot_loader, owns wcnt, the handshake and the write-port drive. It outputs a load_done pulse.
- imem_fetch_ctrl keeps the FSM, PC and IF register.

Test Plan:
1. Reset, then stream 0x00500093, 0x00A00113, 0x002081B3 (ld_last on the 3rd) -> writes at 0x0/0x4/0x8 with those data; running=1 the next cycle; ld_ready=0 afterwards.
2. After boot, no stall -> if_pc sequence 0x0, 0x4, 0x8 with if_inst matching memory and if_valid=1 from the 1st RUN cycle+1.
3. Stall held 2 cycles at pc=0x8 -> if_pc/if_inst hold at 0x4 value, imem_addr stays 0x8; fetch resumes at 0x8.
4. br_taken=1, br_target=0x0000_0006, with stall=1 simultaneously -> next cycle if_inst=0x00000013, if_valid=0, imem_addr=0x4; next fetch if_pc=0x4.
5. DEPTH=4, run sequentially -> after if_pc=0xC, next edge halted=1, if_valid=0; a later br_taken has no effect.
6. rst asserted after 2 of 5 load beats, then reload 1 word with ld_last -> write at 0x0; the counter restarted at 0; RUN entered.
